// File: rtl/ct_pmp_csr_ctrl_if.sv
// CSR request/response channel between CP0 and the PMP register block.
// The master drives the request side; the slave (PMP block) returns the
// ready, the response strobe and the read data/illegal flags.
interface ct_pmp_csr_ctrl_if;
    logic        cp0_pmp_req_vld;
    logic        cp0_pmp_req_wen;
    logic [11:0] cp0_pmp_req_addr;
    logic [63:0] cp0_pmp_wdata;
    logic        pmp_cp0_req_rdy;
    logic        pmp_cp0_rsp_vld;
    logic [63:0] pmp_cp0_rdata;
    logic        pmp_cp0_rsp_illegal;

    modport master (
        output cp0_pmp_req_vld, cp0_pmp_req_wen, cp0_pmp_req_addr, cp0_pmp_wdata,
        input  pmp_cp0_req_rdy, pmp_cp0_rsp_vld, pmp_cp0_rdata, pmp_cp0_rsp_illegal
    );

    modport slave (
        input  cp0_pmp_req_vld, cp0_pmp_req_wen, cp0_pmp_req_addr, cp0_pmp_wdata,
        output pmp_cp0_req_rdy, pmp_cp0_rsp_vld, pmp_cp0_rdata, pmp_cp0_rsp_illegal
    );
endinterface

// File: rtl/ct_pmp_csr_ctrl.sv
// PMP CSR controller: holds pmpcfg0 and pmpaddr0-7 for eight PMP entries,
// serves CP0 reads/writes, and holds register commits off while the MMU has
// a PMP check in flight. pmpcfg2 is hardwired to zero.
module ct_pmp_csr_ctrl (
    input  logic                 forever_cpuclk,
    input  logic                 cpurst,
    ct_pmp_csr_ctrl_if.slave     csr,
    input  logic                 mmu_pmp_busy,
    output logic                 pmp_mmu_cfg_upd,
    output logic [63:0]          pmpcfg0_value,
    output logic [63:0]          pmpcfg2_value,
    output logic [28:0]          pmpaddr0_value,
    output logic [28:0]          pmpaddr1_value,
    output logic [28:0]          pmpaddr2_value,
    output logic [28:0]          pmpaddr3_value,
    output logic [28:0]          pmpaddr4_value,
    output logic [28:0]          pmpaddr5_value,
    output logic [28:0]          pmpaddr6_value,
    output logic [28:0]          pmpaddr7_value
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [7:0][7:0]   cfg_q;          // one byte per entry: L,00,A[1:0],X,W,R
    logic [7:0][28:0]  addr_q;         // stored pmpaddr[37:9]
    logic [11:0]       pend_addr_q;
    logic [63:0]       pend_wdata_q;
    logic [63:0]       rdata_q;
    logic              illegal_q;
    logic              upd_q;          // a commit happened for the current response

    logic              accept, commit, rdy, rsp_vld;
    logic              req_cfg0, req_cfg2, req_paddr, req_legal;
    logic              pend_cfg0, pend_paddr;
    logic [2:0]        req_idx, pend_idx;
    logic              req_napot;
    logic [63:0]       rd_val;
    logic [7:0]        addr_lock;

    // Legalize one written cfg byte: reserved bits 0, NA4 -> OFF, W without R drops W.
    function automatic logic [7:0] cfg_warl(input logic [7:0] b);
        logic [1:0] a;
        a = (b[4:3] == 2'b10) ? 2'b00 : b[4:3];
        return {b[7], 2'b00, a, b[2], b[1] & b[0], b[0]};
    endfunction

    assign req_cfg0   = (csr.cp0_pmp_req_addr == 12'h3A0);
    assign req_cfg2   = (csr.cp0_pmp_req_addr == 12'h3A2);
    assign req_paddr  = (csr.cp0_pmp_req_addr[11:3] == 9'h076);
    assign req_legal  = req_cfg0 | req_cfg2 | req_paddr;
    assign req_idx    = csr.cp0_pmp_req_addr[2:0];
    assign pend_cfg0  = (pend_addr_q == 12'h3A0);
    assign pend_paddr = (pend_addr_q[11:3] == 9'h076);
    assign pend_idx   = pend_addr_q[2:0];
    assign req_napot  = (cfg_q[req_idx][4:3] == 2'b11);

    // pmpaddrN is frozen by its own lock, or by a locked TOR entry N+1 that uses it as base.
    always_comb begin
        addr_lock = '0;
        for (int n = 0; n < 8; n++) begin
            addr_lock[n] = cfg_q[n][7];
            if (n < 7)
                addr_lock[n] = addr_lock[n] | (cfg_q[n+1][7] & (cfg_q[n+1][4:3] == 2'b01));
        end
    end

    // Read image of the requested CSR from the current register contents.
    always_comb begin
        rd_val = '0;
        if (req_cfg0)
            rd_val = cfg_q;
        else if (req_paddr)
            rd_val = {26'd0, addr_q[req_idx][28:1], req_napot & addr_q[req_idx][0],
                      req_napot ? 9'h1FF : 9'h000};
    end

    // FSM state register.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state and handshake controls.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        commit  = 1'b0;
        rdy     = 1'b0;
        rsp_vld = 1'b0;
        case (state_q)
            IDLE: begin
                rdy = 1'b1;
                if (csr.cp0_pmp_req_vld) begin
                    accept  = 1'b1;
                    state_d = (csr.cp0_pmp_req_wen && req_legal) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (!mmu_pmp_busy) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_vld = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture request and response data at acceptance; flag commits for the upd pulse.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            rdata_q      <= '0;
            illegal_q    <= 1'b0;
            upd_q        <= 1'b0;
        end else if (accept) begin
            pend_addr_q  <= csr.cp0_pmp_req_addr;
            pend_wdata_q <= csr.cp0_pmp_wdata;
            rdata_q      <= csr.cp0_pmp_req_wen ? 64'd0 : rd_val;
            illegal_q    <= ~req_legal;
            upd_q        <= 1'b0;
        end else if (commit) begin
            upd_q        <= 1'b1;
        end
    end

    // Commit the pending write into cfg/addr registers, honouring lock rules.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            cfg_q  <= '0;
            addr_q <= '0;
        end else if (commit) begin
            if (pend_cfg0) begin
                for (int n = 0; n < 8; n++)
                    if (!cfg_q[n][7])
                        cfg_q[n] <= cfg_warl(pend_wdata_q[n*8 +: 8]);
            end
            if (pend_paddr && !addr_lock[pend_idx])
                addr_q[pend_idx] <= pend_wdata_q[37:9];
        end
    end

    assign csr.pmp_cp0_req_rdy     = rdy;
    assign csr.pmp_cp0_rsp_vld     = rsp_vld;
    assign csr.pmp_cp0_rdata       = rsp_vld ? rdata_q : 64'd0;
    assign csr.pmp_cp0_rsp_illegal = rsp_vld & illegal_q;
    assign pmp_mmu_cfg_upd         = rsp_vld & upd_q;

    assign pmpcfg0_value  = cfg_q;
    assign pmpcfg2_value  = 64'd0;
    assign pmpaddr0_value = addr_q[0];
    assign pmpaddr1_value = addr_q[1];
    assign pmpaddr2_value = addr_q[2];
    assign pmpaddr3_value = addr_q[3];
    assign pmpaddr4_value = addr_q[4];
    assign pmpaddr5_value = addr_q[5];
    assign pmpaddr6_value = addr_q[6];
    assign pmpaddr7_value = addr_q[7];

endmodule

// File: tb/tb_ct_pmp_csr_ctrl.sv
// Testbench for ct_pmp_csr_ctrl: directed scenarios plus randomized CSR
// traffic compared against a behavioural model of the PMP registers.
module tb_ct_pmp_csr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic        upd;
    logic [63:0] cfg0_o, cfg2_o;
    logic [28:0] pa0, pa1, pa2, pa3, pa4, pa5, pa6, pa7;
    logic [28:0] dut_addr [8];

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_cfg  [8];
    logic [28:0] m_addr [8];
    logic [63:0] last_rd;
    logic        last_ill;

    ct_pmp_csr_ctrl_if csr();

    ct_pmp_csr_ctrl dut (
        .forever_cpuclk  (clk),
        .cpurst          (rst),
        .csr             (csr.slave),
        .mmu_pmp_busy    (busy),
        .pmp_mmu_cfg_upd (upd),
        .pmpcfg0_value   (cfg0_o),
        .pmpcfg2_value   (cfg2_o),
        .pmpaddr0_value  (pa0),
        .pmpaddr1_value  (pa1),
        .pmpaddr2_value  (pa2),
        .pmpaddr3_value  (pa3),
        .pmpaddr4_value  (pa4),
        .pmpaddr5_value  (pa5),
        .pmpaddr6_value  (pa6),
        .pmpaddr7_value  (pa7)
    );

    assign dut_addr[0] = pa0;
    assign dut_addr[1] = pa1;
    assign dut_addr[2] = pa2;
    assign dut_addr[3] = pa3;
    assign dut_addr[4] = pa4;
    assign dut_addr[5] = pa5;
    assign dut_addr[6] = pa6;
    assign dut_addr[7] = pa7;

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    function automatic bit m_legal(input logic [11:0] a);
        return (a == 12'h3A0) || (a == 12'h3A2) || (a >= 12'h3B0 && a <= 12'h3B7);
    endfunction

    function automatic logic [63:0] m_cfg_img();
        logic [63:0] v;
        v = 64'd0;
        for (int n = 0; n < 8; n++) v = v | (64'(m_cfg[n]) << (8 * n));
        return v;
    endfunction

    function automatic logic [63:0] m_read(input logic [11:0] a);
        logic [63:0] v;
        int i;
        v = 64'd0;
        if (a == 12'h3A0) v = m_cfg_img();
        else if (a >= 12'h3B0 && a <= 12'h3B7) begin
            i = int'(a - 12'h3B0);
            v = 64'(m_addr[i]) << 9;
            if (m_cfg[i][4:3] == 2'b11) v = v | 64'h1FF;
            else                        v = v & ~64'h200;
        end
        return v;
    endfunction

    task automatic m_write(input logic [11:0] a, input logic [63:0] d);
        logic [7:0] b;
        int i;
        bit lk;
        if (a == 12'h3A0) begin
            for (int n = 0; n < 8; n++) begin
                if (!m_cfg[n][7]) begin
                    b = d[8*n +: 8];
                    b[6:5] = 2'b00;
                    if (b[4:3] == 2'b10) b[4:3] = 2'b00;
                    if (b[1:0] == 2'b10) b[1] = 1'b0;
                    m_cfg[n] = b;
                end
            end
        end else if (a >= 12'h3B0 && a <= 12'h3B7) begin
            i  = int'(a - 12'h3B0);
            lk = m_cfg[i][7];
            if (i < 7 && m_cfg[i+1][7] && m_cfg[i+1][4:3] == 2'b01) lk = 1'b1;
            if (!lk) m_addr[i] = d[37:9];
        end
    endtask

    task automatic m_reset();
        for (int n = 0; n < 8; n++) begin
            m_cfg[n]  = 8'd0;
            m_addr[n] = 29'd0;
        end
    endtask

    // One CSR transaction; nb = busy cycles seen in WAIT.
    task automatic xact(input bit wen, input logic [11:0] a, input logic [63:0] d, input int nb);
        bit          lw, stall_bad;
        int          lat, exp_lat;
        logic [63:0] exp_rd, snap_cfg;
        logic [28:0] snap_a [8];
        lw      = wen && m_legal(a);
        exp_rd  = m_read(a);
        exp_lat = lw ? nb + 2 : 1;
        @(negedge clk);
        checks++;
        if (csr.pmp_cp0_req_rdy !== 1'b1) begin
            errors++; $display("FAIL rdy_idle: got %b want 1", csr.pmp_cp0_req_rdy);
        end
        snap_cfg = cfg0_o;
        for (int n = 0; n < 8; n++) snap_a[n] = dut_addr[n];
        csr.cp0_pmp_req_vld  = 1'b1;
        csr.cp0_pmp_req_wen  = wen;
        csr.cp0_pmp_req_addr = a;
        csr.cp0_pmp_wdata    = d;
        busy                 = (nb > 0);
        @(posedge clk);
        @(negedge clk);
        csr.cp0_pmp_req_vld = 1'b0;
        csr.cp0_pmp_wdata   = $urandom();
        lat = 1;
        while (csr.pmp_cp0_rsp_vld !== 1'b1 && lat < 64) begin
            if (lat > nb) busy = 1'b0;
            stall_bad = (csr.pmp_cp0_req_rdy !== 1'b0) || (upd !== 1'b0) || (cfg0_o !== snap_cfg);
            for (int n = 0; n < 8; n++) if (dut_addr[n] !== snap_a[n]) stall_bad = 1'b1;
            checks++;
            if (stall_bad) begin
                errors++;
                $display("FAIL wait_stall: rdy=%b upd=%b cfg0=%h want rdy=0 upd=0 cfg0=%h", csr.pmp_cp0_req_rdy, upd, cfg0_o, snap_cfg);
            end
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++; $display("FAIL latency addr=%h: got %0d want %0d", a, lat, exp_lat);
        end
        last_rd  = csr.pmp_cp0_rdata;
        last_ill = csr.pmp_cp0_rsp_illegal;
        checks++;
        if (last_ill !== !m_legal(a)) begin
            errors++; $display("FAIL illegal addr=%h: got %b want %b", a, last_ill, !m_legal(a));
        end
        checks++;
        if (upd !== lw) begin
            errors++; $display("FAIL upd addr=%h: got %b want %b", a, upd, lw);
        end
        if (!lw) begin
            checks++;
            if (last_rd !== exp_rd) begin
                errors++; $display("FAIL rdata addr=%h: got %h want %h", a, last_rd, exp_rd);
            end
        end
        if (lw) m_write(a, d);
        @(negedge clk);
        busy = 1'b0;
        checks++;
        if (csr.pmp_cp0_rsp_vld !== 1'b0 || upd !== 1'b0 || csr.pmp_cp0_req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL rsp_pulse: rsp_vld=%b upd=%b rdy=%b want 0 0 1", csr.pmp_cp0_rsp_vld, upd, csr.pmp_cp0_req_rdy);
        end
        checks++;
        if (cfg0_o !== m_cfg_img() || cfg2_o !== 64'd0) begin
            errors++; $display("FAIL cfg_img: got %h/%h want %h/0", cfg0_o, cfg2_o, m_cfg_img());
        end
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (dut_addr[n] !== m_addr[n]) begin
                errors++; $display("FAIL addr_img[%0d]: got %h want %h", n, dut_addr[n], m_addr[n]);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        m_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (csr.pmp_cp0_rdata !== 64'd0 || csr.pmp_cp0_rsp_vld !== 1'b0 || upd !== 1'b0 || csr.pmp_cp0_rsp_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs: rdata=%h rsp=%b upd=%b ill=%b want all 0", csr.pmp_cp0_rdata, csr.pmp_cp0_rsp_vld, upd, csr.pmp_cp0_rsp_illegal);
        end
        checks++;
        if (cfg0_o !== 64'd0 || pa0 !== 29'd0 || pa7 !== 29'd0) begin
            errors++; $display("FAIL reset_regs: cfg0=%h pa0=%h pa7=%h want 0", cfg0_o, pa0, pa7);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (csr.pmp_cp0_req_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_rdy: got %b want 1", csr.pmp_cp0_req_rdy);
        end
    endtask

    task automatic test_random();
        int          r, nb;
        logic [11:0] a;
        logic [63:0] d;
        bit          wen;
        for (int k = 0; k < 80; k++) begin
            r   = $urandom_range(0, 15);
            wen = $urandom_range(0, 1) == 1;
            d   = {$urandom(), $urandom()};
            nb  = $urandom_range(0, 3);
            if (r < 8)       a = 12'h3B0 + 12'(r);
            else if (r < 10) a = 12'h3A0;
            else if (r == 10) a = 12'h3A2;
            else if (r < 13) begin
                a = 12'($urandom_range(0, 4095));
                if (m_legal(a)) a = 12'hFFF;
            end else begin
                a = 12'h3B0 + 12'($urandom_range(0, 7));
                wen = 1'b0;
            end
            if (a == 12'h3A0 && $urandom_range(0, 7) != 0) d = d & ~64'h8080_8080_8080_8080;
            xact(wen, a, d, nb);
        end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        csr.cp0_pmp_req_vld  = 1'b1;
        csr.cp0_pmp_req_wen  = 1'b1;
        csr.cp0_pmp_req_addr = 12'h3B4;
        csr.cp0_pmp_wdata    = 64'hFFFF_FFFF_FFFF_FFFF;
        busy                 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        csr.cp0_pmp_req_vld = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_reset();
        #1;
        checks++;
        if (csr.pmp_cp0_rsp_vld !== 1'b0 || csr.pmp_cp0_rdata !== 64'd0 || upd !== 1'b0 || cfg0_o !== 64'd0 || pa4 !== 29'd0) begin
            errors++;
            $display("FAIL rst_in_wait: rsp=%b rdata=%h upd=%b cfg0=%h pa4=%h want all 0", csr.pmp_cp0_rsp_vld, csr.pmp_cp0_rdata, upd, cfg0_o, pa4);
        end
        @(negedge clk);
        rst  = 1'b0;
        busy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (csr.pmp_cp0_rsp_vld !== 1'b0 || csr.pmp_cp0_req_rdy !== 1'b1 || pa4 !== 29'd0) begin
                errors++;
                $display("FAIL post_rst_idle: rsp=%b rdy=%b pa4=%h want 0 1 0", csr.pmp_cp0_rsp_vld, csr.pmp_cp0_req_rdy, pa4);
            end
        end
    endtask

    task automatic test_addr_write();
        xact(1'b1, 12'h3B0, 64'h0000_0000_8000_01FF, 0);
        checks++;
        if (pa0 !== 29'h0400000) begin
            errors++; $display("FAIL addr0_value: got %h want 0400000", pa0);
        end
    endtask

    task automatic test_cfg_lock();
        xact(1'b1, 12'h3A0, 64'h0000_0000_0000_009B, 0);
        xact(1'b0, 12'h3A0, 64'd0, 0);
        checks++;
        if (last_rd[7:0] !== 8'h9B) begin
            errors++; $display("FAIL cfg0_read: got %h want 9b", last_rd[7:0]);
        end
        xact(1'b1, 12'h3A0, 64'd0, 0);
        checks++;
        if (cfg0_o[7:0] !== 8'h9B) begin
            errors++; $display("FAIL cfg0_locked: got %h want 9b", cfg0_o[7:0]);
        end
        xact(1'b1, 12'h3B0, 64'h0000_0000_0000_1000, 0);
        checks++;
        if (pa0 !== 29'h0400000) begin
            errors++; $display("FAIL addr0_locked: got %h want 0400000", pa0);
        end
        xact(1'b0, 12'h3B0, 64'd0, 0);
        checks++;
        if (last_rd !== 64'h0000_0000_8000_01FF) begin
            errors++; $display("FAIL addr0_napot_read: got %h want 80001ff", last_rd);
        end
    endtask

    task automatic test_tor_lock();
        xact(1'b1, 12'h3A0, 64'h0000_0000_0000_8D00, 0);
        checks++;
        if (cfg0_o[15:0] !== 16'h8D9B) begin
            errors++; $display("FAIL cfg0_tor: got %h want 8d9b", cfg0_o[15:0]);
        end
        xact(1'b1, 12'h3B1, 64'h0000_0000_0000_2000, 0);
        checks++;
        if (pa1 !== 29'd0) begin
            errors++; $display("FAIL addr1_locked: got %h want 0", pa1);
        end
        xact(1'b1, 12'h3B2, 64'h0000_0000_0000_4000, 0);
        checks++;
        if (pa2 !== 29'h20) begin
            errors++; $display("FAIL addr2_write: got %h want 20", pa2);
        end
    endtask

    task automatic test_warl();
        xact(1'b1, 12'h3A0, 64'h0000_0000_1B12_0000, 0);
        checks++;
        if (cfg0_o[31:16] !== 16'h1B00) begin
            errors++; $display("FAIL cfg_warl: got %h want 1b00", cfg0_o[31:16]);
        end
    endtask

    task automatic test_busy_stall();
        xact(1'b1, 12'h3B3, 64'h0000_0000_000A_BC00, 5);
        checks++;
        if (pa3 !== 29'h55E) begin
            errors++; $display("FAIL addr3_after_busy: got %h want 55e", pa3);
        end
    endtask

    task automatic test_illegal_and_cfg2();
        xact(1'b0, 12'h3A1, 64'd0, 0);
        checks++;
        if (last_ill !== 1'b1 || last_rd !== 64'd0) begin
            errors++; $display("FAIL illegal_3a1: ill=%b rdata=%h want 1 0", last_ill, last_rd);
        end
        xact(1'b1, 12'h3C0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        xact(1'b1, 12'h3A2, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        xact(1'b0, 12'h3A2, 64'd0, 0);
        checks++;
        if (last_rd !== 64'd0 || cfg2_o !== 64'd0) begin
            errors++; $display("FAIL cfg2_zero: rdata=%h img=%h want 0", last_rd, cfg2_o);
        end
    endtask

    initial begin
        rst                  = 1'b1;
        busy                 = 1'b0;
        csr.cp0_pmp_req_vld  = 1'b0;
        csr.cp0_pmp_req_wen  = 1'b0;
        csr.cp0_pmp_req_addr = 12'd0;
        csr.cp0_pmp_wdata    = 64'd0;
        last_rd              = 64'd0;
        last_ill             = 1'b0;
        test_reset();
        test_random();
        test_reset_in_wait();
        test_addr_write();
        test_cfg_lock();
        test_tor_lock();
        test_warl();
        test_busy_stall();
        test_illegal_and_cfg2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ct_pmp_csr_ctrl.md
CT_PMP_CSR_CTRL -- requirements
Module: ct_pmp_csr_ctrl

Interface
REQ-001 The block SHALL have exactly one clock, forever_cpuclk, and one asynchronous active-high reset, cpurst.
REQ-002 forever_cpuclk  in  1  clock; all state updates on its rising edge.
REQ-003 cpurst  in  1  asynchronous active-high reset.
REQ-004 cp0_pmp_req_vld  in  1  CSR access request valid.
REQ-005 cp0_pmp_req_wen  in  1  1 = write, 0 = read.
REQ-006 cp0_pmp_req_addr  in  12  CSR address.
REQ-007 cp0_pmp_wdata  in  64  write data.
REQ-008 mmu_pmp_busy  in  1  a PMP check is in flight in the MMU; register commits must stall.
REQ-009 pmp_cp0_req_rdy  out  1  request accepted when vld & rdy.
REQ-010 pmp_cp0_rsp_vld  out  1  one-cycle response strobe.
REQ-011 pmp_cp0_rdata  out  64  read data, valid with rsp_vld.
REQ-012 pmp_cp0_rsp_illegal  out  1  unimplemented CSR address, valid with rsp_vld.
REQ-013 pmp_mmu_cfg_upd  out  1  one-cycle pulse after a write commits; the MMU flushes cached PMP flags on it.
REQ-014 pmpcfg0_value, pmpcfg2_value  out  64 each  configuration images for the access checker.
REQ-015 pmpaddr0_value .. pmpaddr7_value  out  29 each  stored address bits PA[39:12] plus the NAPOT bit, as the stored pmpaddr[37:9].

Function
REQ-016 Legal addresses SHALL be: 0x3A0 pmpcfg0, 0x3A2 pmpcfg2, and 0x3B0-0x3B7 pmpaddr0-7; every other address is illegal.
REQ-017 The FSM SHALL have three states, IDLE, WAIT and RESP; pmp_cp0_req_rdy = 1 only in IDLE.
REQ-018 IDLE, on accepted read or illegal-address request: SHALL capture rdata/illegal and go to RESP.
REQ-019 IDLE, on accepted legal write: SHALL capture addr/wdata and go to WAIT.
REQ-020 WAIT: when mmu_pmp_busy = 0, SHALL commit the write at that edge and go to RESP; otherwise SHALL stay in WAIT indefinitely.
REQ-021 RESP: SHALL assert rsp_vld for exactly one cycle and return to IDLE.
REQ-022 pmp_mmu_cfg_upd SHALL be asserted in RESP only after a write commit, including a commit whose write was fully ignored by lock rules.
REQ-023 Latency SHALL be as follows: read/illegal rsp_vld one cycle after acceptance; write rsp_vld two cycles after acceptance when busy = 0, plus one cycle per busy cycle in WAIT.
REQ-024 Requests while not in IDLE SHALL be ignored. The response has no backpressure.
REQ-025 Illegal access SHALL return rdata = 0 and illegal = 1, and SHALL change no register.
REQ-026 pmpcfg0 byte n (n = 0..7) layout SHALL be: [7] L, [6:5] reserved, [4:3] A, [2:0] X/W/R.
REQ-027 The reserved bits SHALL always read 0.
REQ-028 A byte with stored L = 1 SHALL ignore writes; unlocked bytes update independently.
REQ-029 WARL rules per written unlocked byte: A = 2'b10 (NA4, unsupported) SHALL store 2'b00; W = 1 with R = 0 SHALL store W = 0.
REQ-030 pmpcfg2 SHALL be hardwired to 0: writes commit nothing, reads return 0, and upd is still pulsed.
REQ-031 A pmpaddrN write SHALL store wdata[37:9] unless either condition holds, in which case it is ignored: cfgN.L = 1, or (N < 7 and cfg(N+1).L = 1 and cfg(N+1).A = TOR 2'b01).
REQ-032 pmpaddrN read SHALL return bits [63:38] = 0 and bits [37:9] = stored value.
REQ-033 For the read low bits: when cfgN.A = NAPOT (2'b11), bits [8:0] = 9'h1FF; otherwise bit 9 reads 0 and bits [8:0] = 0.
REQ-034 Read data SHALL reflect register contents at the acceptance edge.
REQ-035 The 64-bit and 29-bit output images SHALL be direct register outputs, changing only at commit edges.

Reset
REQ-036 On cpurst assertion, the block SHALL immediately go to IDLE, with all cfg/addr registers = 0 and rsp_vld, upd and illegal = 0.
REQ-037 During reset, pmp_cp0_rdata SHALL be 0 and req_rdy SHALL be 1 once cpurst deasserts.
REQ-038 Reset asserted in WAIT or RESP SHALL drop the pending transaction with no commit and no response.

Verification
REQ-039 Write 0x3B0 = 0x0000_0000_8000_01FF with busy = 0 -> rsp_vld at cycle+2; pmpaddr0_value = 0x0400000; upd pulses once.
REQ-040 Write pmpcfg0 = 0x0000_0000_0000_009B, then read 0x3A0 -> byte0 reads 0x9B; a later write of 0x00 to byte0 leaves 0x9B; a write to 0x3B0 is ignored.
REQ-041 Write pmpcfg0 byte1 = 0x8D (L, TOR, X, R), then write 0x3B0 = 0x1000 -> pmpaddr0 unchanged; a write to 0x3B1 is ignored.
REQ-042 Write pmpcfg0 byte2 = 0x12 (NA4, W only) -> stored byte2 = 0x00.
REQ-043 Hold busy = 1 for 5 cycles during a write -> outputs unchanged, req_rdy = 0 throughout; commit on the first busy = 0 edge, rsp_vld one cycle later.
REQ-044 Read 0x3A1 -> rsp_vld + illegal = 1, rdata = 0; assert cpurst while in WAIT -> no commit, no rsp_vld, IDLE after release.
